// File: rtl/systolic_skew_feeder_if.sv
// Row-input handshake bundle for systolic_skew_feeder: upstream (master) offers
// packed 5-lane rows, the feeder (slave) answers with in_ready.
interface systolic_skew_feeder_if #(
  parameter int WIDTH = 8
) ();
  logic               in_valid;
  logic               in_ready;
  logic [5*WIDTH-1:0] in_data;
  logic               in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/systolic_skew_feeder.sv
// Skews 5-lane rows into diagonal order for a systolic array and flushes zero beats after each burst.
// Optional macro SKEW_LANE_VALID_EN adds per-lane validity tags carried alongside the data.
module systolic_skew_feeder #(
  parameter int WIDTH        = 8,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  clear,
  systolic_skew_feeder_if.slave in_bus,
  output logic [WIDTH-1:0]      data_out1,
  output logic [WIDTH-1:0]      data_out2,
  output logic [WIDTH-1:0]      data_out3,
  output logic [WIDTH-1:0]      data_out4,
  output logic [WIDTH-1:0]      data_out5,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            beat_count,
  output logic [4:0]            lane_valid
);

  localparam int LANES = 5;
  localparam int CW    = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    flush_cnt;
  logic             ready;
  logic             accept;
  logic             flush_end;
  logic [WIDTH-1:0] lane_out [LANES];

  assign accept          = in_bus.in_valid && ready;
  assign in_bus.in_ready = ready;
  // A zero count covers FLUSH_CYCLES=0: FLUSH still lasts one cycle.
  assign flush_end = (state == FLUSH) && ((flush_cnt == '0) || (flush_cnt == CW'(1)));

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, STREAM: if (accept) state_nxt = in_bus.in_last ? FLUSH : STREAM;
      FLUSH:        if (flush_end) state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    ready = (state != FLUSH) && !clear;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      flush_cnt  <= '0;
      done       <= 1'b0;
      beat_count <= 8'd0;
    end else begin
      done <= flush_end;
      if ((state != FLUSH) && (state_nxt == FLUSH)) begin
        flush_cnt <= CW'(FLUSH_CYCLES);
      end else if ((state == FLUSH) && (flush_cnt != '0)) begin
        flush_cnt <= flush_cnt - CW'(1);
      end
      if (flush_end) begin
        beat_count <= 8'd0;
      end else if (accept && (beat_count != 8'hFF)) begin
        beat_count <= beat_count + 8'd1;
      end
    end
  end

  // Lane k gets k+1 stages; bubbles insert zeros so the diagonal never slips.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WIDTH-1:0] dly_p [0:k];

    always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
        for (int i = 0; i <= k; i++) dly_p[i] <= '0;
      end else begin
        dly_p[0] <= accept ? in_bus.in_data[WIDTH*k +: WIDTH] : '0;
        for (int i = 1; i <= k; i++) dly_p[i] <= dly_p[i-1];
      end
    end

    assign lane_out[k] = dly_p[k];

`ifdef SKEW_LANE_VALID_EN
    logic [k:0] tag_p;

    always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
        tag_p <= '0;
      end else begin
        tag_p[0] <= accept;
        for (int i = 1; i <= k; i++) tag_p[i] <= tag_p[i-1];
      end
    end

    assign lane_valid[k] = tag_p[k];
`endif
  end

`ifndef SKEW_LANE_VALID_EN
  assign lane_valid = '0;
`endif

  assign data_out1 = lane_out[0];
  assign data_out2 = lane_out[1];
  assign data_out3 = lane_out[2];
  assign data_out4 = lane_out[3];
  assign data_out5 = lane_out[4];

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: history-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_systolic_skew_feeder;

  localparam int W  = 8;
  localparam int FC = 4;
  localparam int HN = 4096;

  logic clk = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  systolic_skew_feeder_if #(.WIDTH(W)) bus ();

  logic [W-1:0] data_out1, data_out2, data_out3, data_out4, data_out5;
  logic         busy, done;
  logic [7:0]   beat_count;
  logic [4:0]   lane_valid;
  logic [W-1:0] dout [5];

  systolic_skew_feeder #(.WIDTH(W), .FLUSH_CYCLES(FC)) dut (
    .clk        (clk),
    .clear      (clear),
    .in_bus     (bus),
    .data_out1  (data_out1),
    .data_out2  (data_out2),
    .data_out3  (data_out3),
    .data_out4  (data_out4),
    .data_out5  (data_out5),
    .busy       (busy),
    .done       (done),
    .beat_count (beat_count),
    .lane_valid (lane_valid)
  );

  assign dout[0] = data_out1;
  assign dout[1] = data_out2;
  assign dout[2] = data_out3;
  assign dout[3] = data_out4;
  assign dout[4] = data_out5;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a per-edge log of what was accepted, plus burst bookkeeping.
  logic [5*W-1:0] acc_row  [HN];
  bit             acc_flag [HN];
  int  n          = 0;
  int  last_clear = -1;
  int  flush_left = 0;
  int  beats_m    = 0;
  bit  busy_m     = 0;
  bit  done_m     = 0;
  bit  started    = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (n < HN - 1) n++;
      if (clear) begin
        acc_flag[n] = 0;
        last_clear  = n;
        flush_left  = 0;
        beats_m     = 0;
        busy_m      = 0;
        done_m      = 0;
      end else begin
        acc_flag[n] = bus.in_valid && (flush_left == 0);
        acc_row[n]  = bus.in_data;
        done_m      = 0;
        if (flush_left > 0) begin
          flush_left--;
          if (flush_left == 0) begin
            done_m  = 1;
            busy_m  = 0;
            beats_m = 0;
          end
        end else if (acc_flag[n]) begin
          busy_m = 1;
          if (beats_m < 255) beats_m++;
          if (bus.in_last) flush_left = (FC > 0) ? FC : 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        for (int k = 1; k <= 5; k++) begin
          int idx;
          logic [W-1:0] ed;
          bit tg;
          idx = n - k + 1;
          ed  = '0;
          tg  = 0;
          if (!clear && idx >= 0 && idx > last_clear && acc_flag[idx]) begin
            ed = acc_row[idx][W*(k-1) +: W];
            tg = 1;
          end
`ifndef SKEW_LANE_VALID_EN
          tg = 0;
`endif
          check($sformatf("data_out%0d", k), 32'(dout[k-1]), 32'(ed));
          check($sformatf("lane_valid[%0d]", k - 1), 32'(lane_valid[k-1]), 32'(tg));
        end
        check("busy",       32'(busy),        clear ? 32'd0 : 32'(busy_m));
        check("done",       32'(done),        clear ? 32'd0 : 32'(done_m));
        check("beat_count", 32'(beat_count),  clear ? 32'd0 : 32'(beats_m));
        check("in_ready",   32'(bus.in_ready), 32'(!clear && flush_left == 0));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5*W-1:0] row(input int a1, a2, a3, a4, a5);
    return {W'(a5), W'(a4), W'(a3), W'(a2), W'(a1)};
  endfunction

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    idle_in();
    for (int i = 0; i < 40; i++) begin
      step();
      #3;
      if (!busy) break;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  initial begin
    int   cnt;
    bit   seen;
    logic [63:0] r;
    idle_in();
    #1 clear = 1'b1;
    started = 1;
    step();
    step();
    #3;
    check("reset_beat_count", 32'(beat_count), 32'd0);
    check("reset_in_ready",   32'(bus.in_ready), 32'd0);
    clear = 1'b0;

    // Single row, last: each lane appears one cycle later than the previous.
    bus.in_valid = 1'b1;
    bus.in_data  = row(1, 2, 3, 4, 5);
    bus.in_last  = 1'b1;
    step();
    idle_in();
    #3;
    check("single_out1", 32'(data_out1), 32'd1);
    check("single_out2_early", 32'(data_out2), 32'd0);
    for (int k = 2; k <= 5; k++) begin
      step();
      #3;
      check($sformatf("single_out%0d", k), 32'(dout[k-1]), 32'(k));
      if (k == 4) check("single_done_early", 32'(done), 32'd0);
    end
    check("single_done", 32'(done), 32'd1);
    wait_idle();

    // Three back-to-back rows.
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b0;
    bus.in_data  = row(10, 11, 12, 13, 14);
    step();
    bus.in_data = row(20, 21, 22, 23, 24);
    #3 check("three_out1_a", 32'(data_out1), 32'd10);
    step();
    bus.in_data = row(30, 31, 32, 33, 34);
    bus.in_last = 1'b1;
    #3 check("three_out1_b", 32'(data_out1), 32'd20);
    step();
    idle_in();
    #3 check("three_out1_c", 32'(data_out1), 32'd30);
    check("three_beats", 32'(beat_count), 32'd3);
    step();
    step();
    #3 check("three_out5_a", 32'(data_out5), 32'd14);
    step();
    #3 check("three_out5_b", 32'(data_out5), 32'd24);
    step();
    #3 check("three_out5_c", 32'(data_out5), 32'd34);
    check("three_done", 32'(done), 32'd1);
    check("three_beats_zero", 32'(beat_count), 32'd0);
    wait_idle();

    // Row held during FLUSH.
    bus.in_valid = 1'b1;
    bus.in_data  = row(7, 7, 7, 7, 7);
    bus.in_last  = 1'b1;
    step();
    bus.in_data = row(9, 8, 7, 6, 5);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #3;
      if (bus.in_ready) break;
      cnt++;
      step();
    end
    check("hold_ready_low_cycles", 32'(cnt), 32'(FC));
    step();
    idle_in();
    #3 check("hold_accepted_out1", 32'(data_out1), 32'd9);
    wait_idle();

    // Rows with a one-cycle gap.
    begin
      bit gap_v [6] = '{1, 1, 0, 1, 1, 1};
      for (int i = 0; i < 6; i++) begin
        bus.in_valid = gap_v[i];
        bus.in_data  = row(i + 40, i + 50, i + 60, i + 70, i + 80);
        bus.in_last  = (i == 5);
        step();
      end
      idle_in();
      #3 check("gap_beats", 32'(beat_count), 32'd5);
      wait_idle();
    end

    // Clear two cycles into a burst.
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b0;
    bus.in_data  = row(1, 2, 3, 4, 5);
    step();
    step();
    clear = 1'b1;
    #1;
    check("clr_out1",  32'(data_out1), 32'd0);
    check("clr_busy",  32'(busy), 32'd0);
    check("clr_beats", 32'(beat_count), 32'd0);
    check("clr_ready", 32'(bus.in_ready), 32'd0);
    step();
    clear = 1'b0;
    step();
    #3 check("clr_new_burst_beats", 32'(beat_count), 32'd1);
    bus.in_last = 1'b1;
    step();
    wait_idle();

    // Randomized traffic, occasional clear pulses.
    for (int i = 0; i < 600; i++) begin
      r = {$urandom(), $urandom()};
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data  = r[5*W-1:0];
      bus.in_last  = ($urandom_range(0, 9) == 0);
      clear        = ($urandom_range(0, 149) == 0);
      step();
    end
    clear = 1'b0;
    wait_idle();

    // Long burst: beat_count saturates.
    for (int i = 0; i < 300; i++) begin
      r = {$urandom(), $urandom()};
      bus.in_valid = 1'b1;
      bus.in_data  = r[5*W-1:0];
      bus.in_last  = (i == 299);
      step();
    end
    idle_in();
    #3 check("sat_beats", 32'(beat_count), 32'd255);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      #3;
      if (done) begin
        seen = 1;
        break;
      end
    end
    check("sat_done_seen", 32'(seen), 32'd1);
    wait_idle();

    step();
    started = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
